// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, 8N1 frame constants
// and bit-period computation, reused by the TX and RX paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  function automatic int uart_clks_per_bit(
    input int clock_freq,
    input int baud_rate
  );
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO, DEPTH x WIDTH, with flush.
// Ports: i_push/i_din, i_pop/o_dout (head), o_full, o_empty.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush)
      r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, with a small input FIFO.
// Ports: data/valid/ready byte input, tx serial out, busy.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 38400000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soft_reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int CLKS_PER_BIT =
    uart_clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] IDX_MAX =
    4'(UART_DATA_BITS - 1);

  uart_state_t      r_state;
  uart_state_t      w_state_next;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [3:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             w_tx_next;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_bit_end;
  logic             w_last_bit;
  logic [7:0]       w_fifo_dout;

  assign w_push     = valid && !w_full;
  assign ready      = !w_full;
  assign tx         = r_tx;
  assign w_bit_end  = (r_clk_cnt == CNT_MAX);
  assign w_last_bit = (r_bit_idx == IDX_MAX);
  assign busy       = (r_state != IDLE) || !w_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (soft_reset),
    .i_push  (w_push),
    .i_din   (data),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else if (soft_reset) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_tx_next;
      if (r_state == IDLE || w_bit_end)
        r_clk_cnt <= '0;
      else
        r_clk_cnt <= r_clk_cnt + 1'b1;
      if (r_state == DATA && w_bit_end)
        r_bit_idx <= w_last_bit ? '0 : r_bit_idx + 1'b1;
      // byte is owned by the shifter from pop time on
      if (w_pop)
        r_shift <= w_fifo_dout;
      else if (r_state == DATA && w_bit_end)
        r_shift <= r_shift >> 1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:
        if (!w_empty) w_state_next = START;
      START:
        if (w_bit_end) w_state_next = DATA;
      DATA:
        if (w_bit_end && w_last_bit) w_state_next = STOP;
      STOP:
        if (w_bit_end)
          w_state_next = w_empty ? IDLE : START;
      default:
        w_state_next = IDLE;
    endcase
  end

  // tx is registered: compute the level for the next bit
  always_comb begin
    w_pop     = 1'b0;
    w_tx_next = r_tx;
    unique case (r_state)
      IDLE:
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_tx_next = UART_START_BIT;
        end
      START:
        if (w_bit_end) w_tx_next = r_shift[0];
      DATA:
        if (w_bit_end)
          w_tx_next = w_last_bit ? UART_STOP_BIT : r_shift[1];
      STOP:
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_tx_next = UART_START_BIT;
          end else begin
            w_tx_next = UART_STOP_BIT;
          end
        end
      default:
        w_tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 16 clocks per bit.
// Samples 1 time unit after each rising edge.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic       soft_reset;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;

  int checks;
  int errors;

  logic [7:0] q [5];

  uart_tx #(
    .BAUD_RATE  (1),
    .CLOCK_FREQ (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .soft_reset (soft_reset),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .tx         (tx),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // checks frame positions first..last, one tick each
  task automatic check_frame(input logic [7:0] b,
                             input int first,
                             input int last);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = first; i <= last; i++) begin
      chk($sformatf("tx_%02h_p%0d", b, i), 32'(tx),
          32'(bits[i/16]));
      if (i % 16 == 0)
        chk($sformatf("busy_%02h_p%0d", b, i),
            32'(busy), 32'd1);
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    q[0] = 8'h00; q[1] = 8'hFF; q[2] = 8'h55;
    q[3] = 8'hAA; q[4] = 8'h0F;
    rst = 1'b0;
    soft_reset = 1'b0;
    data = 8'h00;
    valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_tx", 32'(tx), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // single byte
    data = 8'hA5; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("a5_acc_tx", 32'(tx), 32'd1);
    chk("a5_acc_busy", 32'(busy), 32'd1);
    tick();
    check_frame(8'hA5, 0, 159);
    chk("a5_end_busy", 32'(busy), 32'd0);
    chk("a5_end_tx", 32'(tx), 32'd1);
    tick();

    // fill: 5 accepted, 6th (0x33) refused
    for (int k = 0; k < 5; k++) begin
      data = q[k]; valid = 1'b1;
      chk($sformatf("fill_ready_%0d", k),
          32'(ready), 32'd1);
      tick();
      if (k >= 1)
        chk($sformatf("fill_tx_%0d", k), 32'(tx), 32'd0);
    end
    data = 8'h33;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("full_ready_%0d", k),
          32'(ready), 32'd0);
      chk($sformatf("full_tx_%0d", k), 32'(tx), 32'd0);
      tick();
    end
    valid = 1'b0;
    check_frame(q[0], 11, 159);
    for (int k = 1; k < 5; k++)
      check_frame(q[k], 0, 159);
    chk("fill_end_busy", 32'(busy), 32'd0);
    chk("fill_end_ready", 32'(ready), 32'd1);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("no33_tx_%0d", k), 32'(tx), 32'd1);
      tick();
    end

    // soft reset mid-frame with 2 queued
    data = 8'h3C; valid = 1'b1;
    tick();
    data = 8'h11;
    tick();
    chk("sr_start_tx", 32'(tx), 32'd0);
    data = 8'h22;
    tick();
    valid = 1'b0;
    check_frame(8'h3C, 1, 49);
    soft_reset = 1'b1; data = 8'h44; valid = 1'b1;
    tick();
    soft_reset = 1'b0; valid = 1'b0;
    chk("sr_tx", 32'(tx), 32'd1);
    chk("sr_busy", 32'(busy), 32'd0);
    chk("sr_ready", 32'(ready), 32'd1);
    for (int k = 0; k < 200; k++) begin
      chk($sformatf("sr_quiet_%0d", k), 32'(tx), 32'd1);
      tick();
    end
    chk("sr_end_busy", 32'(busy), 32'd0);

    // async reset mid data bit
    data = 8'h5A; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    check_frame(8'h5A, 0, 23);
    chk("ar_pre_tx", 32'(tx), 32'd0);
    #3 rst = 1'b1;
    #1;
    chk("ar_tx", 32'(tx), 32'd1);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_ready", 32'(ready), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("ar_rel_tx", 32'(tx), 32'd1);
    chk("ar_rel_busy", 32'(busy), 32'd0);
    data = 8'h81; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("ar_acc_tx", 32'(tx), 32'd1);
    tick();
    check_frame(8'h81, 0, 159);
    chk("ar_end_busy", 32'(busy), 32'd0);

    // push on the edge where STOP ends
    data = 8'h96; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    check_frame(8'h96, 0, 158);
    chk("se_stop_tx", 32'(tx), 32'd1);
    data = 8'hC3; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("se_idle_tx", 32'(tx), 32'd1);
    chk("se_idle_busy", 32'(busy), 32'd1);
    tick();
    check_frame(8'hC3, 0, 159);
    chk("se_end_busy", 32'(busy), 32'd0);
    chk("se_end_tx", 32'(tx), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
